dphy_delay_calib: RTL and testbench
===================================

Name: dphy_delay_calib

Overview:
- Per-lane IDELAY tap calibration scheduler for the D-PHY slave receiver. Runs in the byte clock domain.
- Shares a single sweep engine across all data lanes, one lane at a time in order 0..DATA_LANES-1.
- For each lane it pulses inc_delay through all 32 taps, scores each tap by sync-word hits and packet errors, then parks the lane at the centre of the longest good window.
- Sits between the lane byte aligners and packet ECC checker (inputs) and the data-lane IDELAY inc controls (outputs).

Parameters:
- DATA_LANES, 2, number of lanes calibrated (1..4).
- SETTLE_CYCLES, 16, idle cycles after any inc pulse before measuring.
- MEASURE_CYCLES, 4096, length of the scoring window per tap.
- MIN_SYNC, 4, sync hits required in the window for a tap to count as good.

Ports:
- clk_i  in  1  byte clock.
- rst_i  in  1  asynchronous active-high reset.
- rx_clk_present_i  in  1  HS clock detected; low aborts calibration.
- start_i  in  1  single-cycle pulse that requests (re)calibration.
- sync_i  in  DATA_LANES  per-lane pulse when the aligner locks on sync byte 0xB8.
- err_i  in  1  pulse on packet header ECC/CRC error.
- inc_delay_o  out  DATA_LANES  one-cycle IDELAY increment pulse; tap wraps 31->0.
- tap_o  out  DATA_LANES*5  internally tracked current tap, packed [lane][4:0].
- lane_fail_o  out  DATA_LANES  no good tap found for that lane.
- busy_o  out  1  calibration in progress.
- done_o  out  1  last calibration completed; cleared on start.

Behaviour:
- Reset: every output is 0, tap tracking is 0, FSM is IDLE. Reset may assert in any state; the FSM returns to IDLE asynchronously.
- FSM states: IDLE, REWIND, SETTLE, MEASURE, STEP, CENTER, NEXT_LANE, DONE.
- IDLE: on start_i=1 and rx_clk_present_i=1, go to REWIND with lane=0, set busy_o=1, clear done_o and lane_fail_o. start_i with rx_clk_present_i=0 is dropped. start_i while busy_o=1 is ignored.
- REWIND: for the current lane, issue (32-tap) mod 32 inc pulses, one every SETTLE_CYCLES+1 cycles, until the tap reaches 0. Then go to SETTLE. If the tap is already 0, skip straight to SETTLE.
- inc rule: each pulse is exactly 1 cycle on exactly one lane bit. tap_o for that lane increments mod 32 in the same cycle the pulse is asserted.
- SETTLE: count SETTLE_CYCLES, then go to MEASURE.
- MEASURE: count for MEASURE_CYCLES cycles.
  - sync_cnt counts sync_i[lane] pulses, saturating at MIN_SYNC.
  - err_seen is set on any err_i pulse.
  - The tap is good when sync_cnt>=MIN_SYNC and err_seen=0. The result is stored in a 32-bit good-map at index tap.
  - If tap<31, go to STEP. If tap==31, pulse inc once more (tap wraps to 0) and go to CENTER.
- STEP: one inc pulse, then SETTLE.
- CENTER: find the longest run of 1s in the good-map.
  - Runs are linear only; no wrap across 31->0.
  - Ties go to the lowest start index.
  - centre = start + (len>>1), where len is 6 bits wide.
  - If len==0: set lane_fail_o[lane]=1 and leave the tap at 0.
  - Otherwise issue centre inc pulses, spaced SETTLE_CYCLES+1 apart.
  - The search may be sequential over 32 cycles or combinational; latency is not specified beyond completing before the first centring pulse.
- NEXT_LANE: if lane==DATA_LANES-1, go to DONE; otherwise lane++ and go to REWIND.
- DONE: done_o=1 and busy_o=0 for as long as the FSM is in DONE, then go to IDLE. done_o stays 1 until the next accepted start.
- Clock loss: rx_clk_present_i=0 in any busy state aborts to IDLE on the next cycle.
  - busy_o=0, done_o=0, no inc is issued.
  - The already-calibrated lanes keep their tap_o values.
  - The next start re-rewinds every lane from its tracked tap.
- During a sweep, non-swept lanes receive no inc pulses.

Test Plan:
- 2 lanes, lane0 synced at taps 10..20 and lane1 at taps 3..9, no err -> tap_o lane0=15, lane1=6, lane_fail_o=00, done_o=1. Each lane sees exactly 32 sweep pulses plus its centre count of pulses.
- lane0 good at 0..3 and 28..31 -> tie resolves to the lower start, tap=2. The run across 31->0 is not merged.
- lane0 never receives sync_i -> lane_fail_o[0]=1, tap 0. Lane1 still calibrates normally.
- err_i pulsed during tap 15 of a 10..20 window -> windows become 10..14 and 16..20, tie -> tap=12.
- Drop rx_clk_present_i at tap 7 of lane1 -> busy_o=0 the next cycle, done_o=0. Then re-start -> lane0 rewinds from 15 with 17 pulses, lane1 rewinds from 7 with 25 pulses, and both end with the same results as before.
- start_i pulsed mid-sweep -> ignored. Async rst_i mid-MEASURE -> all outputs 0 immediately.

Source files
------------

// File: rtl/dphy_delay_calib.sv
// Per-lane IDELAY tap calibration for the D-PHY slave receiver (byte clock domain).
// One shared sweep engine scores all 32 taps of each lane in turn, then parks the lane at the centre of its longest good window.
module dphy_delay_calib #(
    parameter int DATA_LANES     = 2,
    parameter int SETTLE_CYCLES  = 16,
    parameter int MEASURE_CYCLES = 4096,
    parameter int MIN_SYNC       = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rx_clk_present_i,
    input  logic                      start_i,
    input  logic [DATA_LANES-1:0]     sync_i,
    input  logic                      err_i,
    output logic [DATA_LANES-1:0]     inc_delay_o,
    output logic [DATA_LANES*5-1:0]   tap_o,
    output logic [DATA_LANES-1:0]     lane_fail_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int LW   = (DATA_LANES > 1) ? $clog2(DATA_LANES) : 1;
    localparam int MAXC = (SETTLE_CYCLES > MEASURE_CYCLES) ? SETTLE_CYCLES : MEASURE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int SW   = $clog2(MIN_SYNC + 1);

    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SPACE_LD  = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] MEAS_LD   = CW'(MEASURE_CYCLES - 1);
    localparam logic [SW-1:0] SYNC_MAX  = SW'(MIN_SYNC);
    localparam logic [LW-1:0] LAST_LANE = LW'(DATA_LANES - 1);

    typedef enum logic [2:0] {
        IDLE, REWIND, SETTLE, MEASURE, STEP, CENTER, NEXT_LANE, DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [LW-1:0]                  lane_q, lane_d;
    logic [DATA_LANES-1:0][4:0]     tap_q, tap_d;
    logic [DATA_LANES-1:0]          inc_q, inc_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [SW-1:0]                  sync_q, sync_d;
    logic                           err_q, err_d;
    logic [31:0]                    map_q, map_d;
    logic [DATA_LANES-1:0]          fail_q, fail_d;
    logic                           done_q, done_d;

    logic [4:0] cur_tap;
    logic       issue_inc;
    logic       busy;
    logic [SW-1:0] sync_nxt;
    logic       err_nxt;

    logic [5:0] run_len, best_len;
    logic [4:0] run_start, best_start, centre;

    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign busy_o      = busy;
    assign done_o      = done_q;
    assign inc_delay_o = inc_q;
    assign tap_o       = tap_q;
    assign lane_fail_o = fail_q;

    // Longest linear run of good taps; strict '>' keeps the lowest start on ties.
    always_comb begin
        run_len    = '0;
        run_start  = '0;
        best_len   = '0;
        best_start = '0;
        for (int i = 0; i < 32; i++) begin
            if (map_q[i]) begin
                if (run_len == 6'd0) run_start = 5'(i);
                run_len = run_len + 6'd1;
                if (run_len > best_len) begin
                    best_len   = run_len;
                    best_start = run_start;
                end
            end else begin
                run_len = '0;
            end
        end
        centre = best_start + best_len[5:1];
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        tap_d     = tap_q;
        inc_d     = '0;
        cnt_d     = cnt_q;
        sync_d    = sync_q;
        err_d     = err_q;
        map_d     = map_q;
        fail_d    = fail_q;
        done_d    = done_q;
        issue_inc = 1'b0;
        cur_tap   = tap_q[lane_q];

        sync_nxt = sync_q;
        if (sync_i[lane_q] && (sync_q != SYNC_MAX)) sync_nxt = sync_q + 1'b1;
        err_nxt = err_q | err_i;

        if (busy && !rx_clk_present_i) begin
            // Losing the HS clock abandons the sweep; tracked taps stay valid.
            state_d = IDLE;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && rx_clk_present_i) begin
                        state_d = REWIND;
                        lane_d  = '0;
                        fail_d  = '0;
                        done_d  = 1'b0;
                        cnt_d   = '0;
                        map_d   = '0;
                    end
                end
                REWIND: begin
                    if (cur_tap == 5'd0) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LD;
                    end else if (cnt_q == '0) begin
                        issue_inc = 1'b1;
                        cnt_d     = SPACE_LD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = MEASURE;
                        cnt_d   = MEAS_LD;
                        sync_d  = '0;
                        err_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                MEASURE: begin
                    sync_d = sync_nxt;
                    err_d  = err_nxt;
                    if (cnt_q == '0) begin
                        map_d[cur_tap] = (sync_nxt == SYNC_MAX) && !err_nxt;
                        if (cur_tap == 5'd31) begin
                            // Wrap back to tap 0 so centring counts up from a known origin.
                            issue_inc = 1'b1;
                            state_d   = CENTER;
                            cnt_d     = SPACE_LD;
                        end else begin
                            state_d = STEP;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                STEP: begin
                    issue_inc = 1'b1;
                    state_d   = SETTLE;
                    cnt_d     = SETTLE_LD;
                end
                CENTER: begin
                    if (best_len == 6'd0) begin
                        fail_d[lane_q] = 1'b1;
                        state_d        = NEXT_LANE;
                    end else if (cur_tap == centre) begin
                        state_d = NEXT_LANE;
                    end else if (cnt_q == '0) begin
                        issue_inc = 1'b1;
                        cnt_d     = SPACE_LD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                NEXT_LANE: begin
                    if (lane_q == LAST_LANE) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        lane_d  = lane_q + 1'b1;
                        state_d = REWIND;
                        cnt_d   = '0;
                        map_d   = '0;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (issue_inc) begin
            inc_d[lane_q] = 1'b1;
            tap_d[lane_q] = cur_tap + 5'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lane_q  <= '0;
            tap_q   <= '0;
            inc_q   <= '0;
            cnt_q   <= '0;
            sync_q  <= '0;
            err_q   <= 1'b0;
            map_q   <= '0;
            fail_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            tap_q   <= tap_d;
            inc_q   <= inc_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            err_q   <= err_d;
            map_q   <= map_d;
            fail_q  <= fail_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_dphy_delay_calib.sv
// Bench for dphy_delay_calib: an IDELAY/sync-source model driven from the tracked inc pulses,
// directed calibration runs, and a result queue checked when done_o rises.
module tb_dphy_delay_calib;

  localparam int NL = 2;
  localparam int SC = 4;
  localparam int MC = 16;
  localparam int MS = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx;
  logic            start;
  logic [NL-1:0]   sync;
  logic            err;
  logic [NL-1:0]   inc_delay_o;
  logic [NL*5-1:0] tap_o;
  logic [NL-1:0]   lane_fail_o;
  logic            busy_o;
  logic            done_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [11:0] exp_q[$];

  logic [4:0] model_tap[NL] = '{default: 5'd0};
  int         pulse_cnt[NL] = '{default: 0};
  int         onehot_viol = 0;
  int         cfg = 0;
  bit         phase = 1'b0;

  dphy_delay_calib #(
    .DATA_LANES(NL),
    .SETTLE_CYCLES(SC),
    .MEASURE_CYCLES(MC),
    .MIN_SYNC(MS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rx_clk_present_i(rx),
    .start_i(start),
    .sync_i(sync),
    .err_i(err),
    .inc_delay_o(inc_delay_o),
    .tap_o(tap_o),
    .lane_fail_o(lane_fail_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Eye model: which taps of each lane see the sync byte for the active scenario.
  function automatic logic is_good(input int c, input int l, input logic [4:0] t);
    if (l == 1) return (t >= 5'd3) && (t <= 5'd9);
    case (c)
      0, 3:    return (t >= 5'd10) && (t <= 5'd20);
      1:       return (t <= 5'd3) || (t >= 5'd28);
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int l = 0; l < NL; l++) model_tap[l] = 5'd0;
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (inc_delay_o[l]) begin
          model_tap[l] = model_tap[l] + 5'd1;
          pulse_cnt[l] = pulse_cnt[l] + 1;
        end
      end
    end
    if ($countones(inc_delay_o) > 1) onehot_viol = onehot_viol + 1;
    phase = ~phase;
    for (int l = 0; l < NL; l++) sync[l] = phase && is_good(cfg, l, model_tap[l]);
    err = phase && (cfg == 3) && (model_tap[0] == 5'd15);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    logic [11:0] e;
    n = 0;
    while (done_o !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    check({tag, "_done"}, done_o, 1);
    check({tag, "_result"}, {lane_fail_o, tap_o}, e);
    check({tag, "_busy_low"}, busy_o, 0);
  endtask

  task automatic wait_tap(input int lane, input logic [4:0] t, input string tag);
    int n;
    n = 0;
    while (model_tap[lane] != t && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reached"}, model_tap[lane], t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, c0, c1;
    rst = 1'b1; rx = 1'b1; start = 1'b0; sync = '0; err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inc", inc_delay_o, 0);
    check("rst_tap", tap_o, 0);
    check("rst_fail", lane_fail_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    @(negedge clk) rst = 1'b0;

    // Start without the HS clock is dropped.
    rx = 1'b0;
    pulse_start();
    @(negedge clk);
    check("start_no_clk", busy_o, 0);
    rx = 1'b1;

    // Abort on clock loss while lane 1 sits at tap 7.
    cfg = 0;
    pulse_start();
    check("busy_on_start", busy_o, 1);
    wait_tap(1, 5'd7, "abort_tap7");
    repeat (5) @(negedge clk);
    rx = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    c0 = pulse_cnt[0];
    c1 = pulse_cnt[1];
    repeat (20) @(negedge clk);
    check("abort_no_inc", pulse_cnt[0] + pulse_cnt[1], c0 + c1);
    check("abort_taps", tap_o, {5'd7, 5'd15});
    rx = 1'b1;

    // Restart rewinds both lanes; a start mid-sweep is ignored.
    @(negedge clk);
    b0 = pulse_cnt[0];
    b1 = pulse_cnt[1];
    exp_q.push_back({2'b00, 5'd6, 5'd15});
    pulse_start();
    repeat (100) @(negedge clk);
    pulse_start();
    check("start_ignored_busy", busy_o, 1);
    wait_done("restart");
    check("restart_pulses_l0", pulse_cnt[0] - b0, 17 + 32 + 15);
    check("restart_pulses_l1", pulse_cnt[1] - b1, 25 + 32 + 6);
    repeat (5) @(negedge clk);
    check("done_holds", done_o, 1);

    // Fresh calibration from reset taps.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    b0 = pulse_cnt[0];
    b1 = pulse_cnt[1];
    exp_q.push_back({2'b00, 5'd6, 5'd15});
    pulse_start();
    wait_done("base");
    check("base_pulses_l0", pulse_cnt[0] - b0, 32 + 15);
    check("base_pulses_l1", pulse_cnt[1] - b1, 32 + 6);

    // Two equal windows split by the 31->0 wrap: lowest start wins.
    cfg = 1;
    exp_q.push_back({2'b00, 5'd6, 5'd2});
    pulse_start();
    check("done_cleared_on_start", done_o, 0);
    wait_done("tie_wrap");

    // Lane 0 never syncs.
    cfg = 2;
    exp_q.push_back({2'b01, 5'd6, 5'd0});
    pulse_start();
    wait_done("no_sync");

    // Error at tap 15 splits the window.
    cfg = 3;
    exp_q.push_back({2'b00, 5'd6, 5'd12});
    pulse_start();
    check("fail_cleared_on_start", lane_fail_o, 0);
    wait_done("err_split");
    check("onehot_inc", onehot_viol, 0);
    check("queue_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of a measurement window.
    cfg = 0;
    pulse_start();
    wait_tap(0, 5'd5, "mid_measure");
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tap", tap_o, 0);
    check("async_rst_busy", busy_o, 0);
    check("async_rst_done", done_o, 0);
    check("async_rst_inc", inc_delay_o, 0);
    check("async_rst_fail", lane_fail_o, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
